// File: rtl/cpu_bus_fabric.sv
// V810 CPU-side bus fabric: N-slave read mux with width extension, bus-cycle FSM,
// wait-state watchdog and sticky error capture with address logging.
module cpu_bus_fabric #(
   parameter int unsigned NUM_SLV    = 6,
   parameter logic [31:0] SLV_WIDTH  = 32'h0000_0E95,
   parameter int unsigned TIMEOUT    = 1024,
   parameter logic [31:0] DEF_DATA   = 32'hFFFF_FFFF,
   parameter logic [31:0] TRAP_A0    = 32'hFFFF_FF90,
   parameter logic [31:0] TRAP_A1    = 32'hFFFF_FFD0,
   parameter bit          STRICT_MAP = 1'b1
) (
   input  logic                   CLK,
   input  logic                   RESn,
   input  logic                   CE,
   input  logic                   BCYSTn,
   input  logic                   MRQn,
   input  logic                   RW,
   input  logic [31:0]            A,
   input  logic [NUM_SLV-1:0]     SLV_CEn,
   input  logic [32*NUM_SLV-1:0]  SLV_DO,
   input  logic [NUM_SLV-1:0]     SLV_READYn,
   output logic [31:0]            CPU_DI,
   output logic                   CPU_READYn,
   output logic                   BUSY,
   input  logic                   ERR_CLR,
   output logic                   ERROR,
   output logic [2:0]             ERR_CODE,
   output logic [31:0]            ERR_ADDR
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [2:0] CODE_NONE  = 3'd0;
   localparam logic [2:0] CODE_TRAP  = 3'd1;
   localparam logic [2:0] CODE_TMO   = 3'd2;
   localparam logic [2:0] CODE_CONFL = 3'd3;
   localparam logic [2:0] CODE_UNMAP = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_TMO} state_t;

   state_t             state;
   logic [CNT_W-1:0]   wait_cnt;
   logic [31:0]        cyc_addr;

   logic               none;
   logic               conflict;
   logic [31:0]        sel_data;
   logic [1:0]         sel_width;
   logic               sel_ready;
   logic [31:0]        ext_data;

   logic               start;
   logic               done;
   logic               trap_ev;
   logic               new_err;
   logic [2:0]         err_code_n;
   logic [31:0]        err_addr_n;

   // Read direction is not needed by the fabric; the bus is read-data only here.
   logic               unused;
   assign unused = RW;

   // Lowest active chip select wins; any further active select flags a conflict.
   always_comb begin
      none      = 1'b1;
      conflict  = 1'b0;
      sel_data  = '0;
      sel_width = 2'd2;
      sel_ready = 1'b1;
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
         if (!SLV_CEn[i]) begin
            if (none) begin
               sel_data  = SLV_DO[32*i +: 32];
               sel_width = SLV_WIDTH[2*i +: 2];
               sel_ready = SLV_READYn[i];
            end else begin
               conflict = 1'b1;
            end
            none = 1'b0;
         end
      end
   end

   always_comb begin
      case (sel_width)
         2'd0:    ext_data = {24'd0, sel_data[7:0]};
         2'd1:    ext_data = {16'd0, sel_data[15:0]};
         default: ext_data = sel_data;
      endcase
   end

   always_comb begin
      CPU_DI = ext_data;
      if (state == S_TMO) CPU_DI = DEF_DATA;
      else if (none)      CPU_DI = '0;
   end

   always_comb begin
      CPU_READYn = 1'b1;
      case (state)
         S_ACTIVE: CPU_READYn = none ? 1'b0 : sel_ready;
         S_TMO:    CPU_READYn = 1'b0;
         default:  CPU_READYn = 1'b1;
      endcase
   end

   assign BUSY  = (state != S_IDLE);
   assign start = !BCYSTn;
   assign done  = (state == S_ACTIVE) && !CPU_READYn;

   // Trap is sampled on every accepted start: from IDLE or back-to-back at cycle end.
   assign trap_ev = start && !MRQn && ((A == TRAP_A0) || (A == TRAP_A1))
                    && ((state == S_IDLE) || done);

   // Error priority: trap > timeout > conflict > unmapped.
   always_comb begin
      new_err    = 1'b1;
      err_code_n = CODE_NONE;
      err_addr_n = cyc_addr;
      if (trap_ev) begin
         err_code_n = CODE_TRAP;
         err_addr_n = A;
      end else if (state == S_TMO) begin
         err_code_n = CODE_TMO;
      end else if ((state == S_ACTIVE) && (wait_cnt == '0) && conflict) begin
         err_code_n = CODE_CONFL;
      end else if (STRICT_MAP && (state == S_ACTIVE) && none) begin
         err_code_n = CODE_UNMAP;
      end else begin
         new_err    = 1'b0;
         err_addr_n = '0;
      end
   end

   // Bus-cycle FSM, wait watchdog and sticky error register.
   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         cyc_addr <= '0;
         ERROR    <= 1'b0;
         ERR_CODE <= CODE_NONE;
         ERR_ADDR <= '0;
      end else if (CE) begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_ACTIVE;
                  cyc_addr <= A;
                  wait_cnt <= '0;
               end
            end
            S_ACTIVE: begin
               if (done) begin
                  if (start) begin
                     cyc_addr <= A;
                     wait_cnt <= '0;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (wait_cnt == TMO_LAST) begin
                  state <= S_TMO;
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            S_TMO:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         if (new_err && (!ERROR || ERR_CLR)) begin
            ERROR    <= 1'b1;
            ERR_CODE <= err_code_n;
            ERR_ADDR <= err_addr_n;
         end else if (ERR_CLR) begin
            ERROR    <= 1'b0;
            ERR_CODE <= CODE_NONE;
            ERR_ADDR <= '0;
         end
      end
   end

endmodule

// File: doc/cpu_bus_fabric.md
Name: cpu_bus_fabric

Overview:
- Parametrised CPU-side bus fabric for the V810 memory/I-O bus. Sits between the CPU and the gate-array chip selects.
- Replaces the fixed priority read-data mux and ad-hoc ERROR trap with an N-slave fabric that adds:
  - per-slave width extension
  - a bus-cycle FSM
  - a wait-state timeout watchdog
  - chip-select conflict and unmapped detection
  - sticky error capture with address logging.

Parameters:
NUM_SLV, 6, number of slave channels (1..16)
SLV_WIDTH, 32'h0000_0E95, 2 bits per slave, slave i at bits [2i+1:2i]: 0=8-bit, 1=16-bit, 2=32-bit, 3=reserved (treated as 32-bit)
TIMEOUT, 1024, CE-qualified wait cycles before forced termination (>=2)
DEF_DATA, 32'hFFFF_FFFF, read data returned on timeout
TRAP_A0, 32'hFFFF_FF90, trap address 0
TRAP_A1, 32'hFFFF_FFD0, trap address 1
STRICT_MAP, 1, 1 = unmapped access is an error

Ports:
CLK in 1 clock
RESn in 1 reset, asynchronous, active-low
CE in 1 clock enable
BCYSTn in 1 CPU bus cycle start
MRQn in 1 CPU memory request
RW in 1 1=read
A in 32 CPU address
SLV_CEn in NUM_SLV slave chip selects, active-low
SLV_DO in 32*NUM_SLV slave read data, slave i at [32i+31:32i]
SLV_READYn in NUM_SLV slave ready, active-low
CPU_DI out 32 read data to CPU
CPU_READYn out 1 ready to CPU
BUSY out 1 bus cycle in progress
ERR_CLR in 1 clears sticky error
ERROR out 1 sticky error flag
ERR_CODE out 3 0=none, 1=trap, 2=timeout, 3=CS conflict, 4=unmapped
ERR_ADDR out 32 address of first error

Behaviour:
- All state updates occur on rising CLK with CE=1. RESn low clears everything asynchronously.
- Reset values: FSM=IDLE, BUSY=0, CPU_READYn=1, CPU_DI=0, ERROR=0, ERR_CODE=0, ERR_ADDR=0, wait counter=0.
- Selection (combinational):
  - sel = lowest index i with SLV_CEn[i]=0.
  - conflict = more than one CEn low.
  - none = all CEn high.
- CPU_DI (combinational): SLV_DO[sel] zero-extended per SLV_WIDTH (8 -> [7:0], 16 -> [15:0]). DEF_DATA in TMO; 0 when none.
- FSM states: IDLE, ACTIVE, TMO.
  - IDLE -> ACTIVE when BCYSTn=0. Latch A into cyc_addr and clear the wait counter.
  - ACTIVE, slave ready:
    - CPU_READYn = SLV_READYn[sel] (combinational passthrough).
    - If 0 -> IDLE, or stay ACTIVE if BCYSTn=0 again (back-to-back: relatch A, clear counter).
  - ACTIVE, none:
    - CPU_READYn=0 immediately with CPU_DI=0, then -> IDLE.
    - Raises unmapped error if STRICT_MAP=1.
  - ACTIVE, slave not ready: counter increments. When counter == TIMEOUT-1 and still not ready -> TMO.
  - TMO: CPU_READYn=0 for exactly one CE cycle, CPU_DI=DEF_DATA, raises timeout error, then -> IDLE.
- CPU_READYn=1 in IDLE.
- BUSY=1 in ACTIVE and TMO.
- Counter: 16-bit, saturating, reset on every cycle start.
- Trap:
  - Fires when BCYSTn=0 and MRQn=0 and A equals TRAP_A0 or TRAP_A1 on a start edge.
  - Checked in IDLE and on back-to-back starts.
- Conflict is checked once per bus cycle, at the first ACTIVE CE.
- Error capture:
  - On the first error while ERROR=0: set ERROR=1, load ERR_CODE, and load ERR_ADDR (cyc_addr, or A for a trap).
  - Later errors are ignored until ERR_CLR.
  - Simultaneous errors resolve by priority trap > timeout > conflict > unmapped.
  - ERR_CLR with a new error in the same CE: the new error is captured, and the clear applies to the old error only.
  - ERR_CLR is only sampled with CE=1.
- CE=0: FSM, counter and errors hold. Combinational outputs still follow their inputs.
- Reset mid-cycle: FSM returns to IDLE and CPU_READYn returns to 1 immediately. A partial cycle does not resume.

Test Plan:
- 16-bit slave 1: read at A=0xFFF00000 with SLV_DO[63:32]=0xDEAD1234, READYn low after 3 CE -> CPU_DI=0x00001234, CPU_READYn low on CE 4, BUSY drops, ERROR=0.
- Timeout, TIMEOUT=8: slave 0 never ready -> CPU_READYn low for 1 CE after 8 wait CEs, CPU_DI=0xFFFFFFFF, ERR_CODE=2, ERR_ADDR=cycle address.
- Conflict: SLV_CEn=6'b111100 -> slave 0 data returned, ERR_CODE=3. A subsequent timeout leaves ERR_CODE=3 until ERR_CLR pulse, then ERROR=0.
- Trap: BCYSTn=0, MRQn=0, A=0xFFFFFF90 -> ERROR=1, ERR_CODE=1, ERR_ADDR=0xFFFFFF90. The same access with MRQn=1 -> no error.
- Unmapped: all CEn high, STRICT_MAP=1 -> immediate CPU_READYn=0, CPU_DI=0, ERR_CODE=4. With STRICT_MAP=0 -> same handshake, ERROR stays 0.
- Async reset: RESn low mid-wait with CE=0 -> CPU_READYn=1, BUSY=0, ERROR=0 without a CLK edge. The next cycle runs normally, with back-to-back BCYSTn starts.
